// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
package hazard_pkg;

  typedef enum logic {
    RUN,
    FLUSH
  } hz_state_t;

  localparam logic [4:0] REG_X0          = 5'd0;
  localparam int         FLUSH_DEPTH_MAX = 7;

endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// Hazard-controller signal bundle: ID/EX operand info in, pipeline enables/clears out.
interface hazard_flush_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1_id;
  logic [4:0]       Rs2_id;
  logic             UsesRs1_id;
  logic             UsesRs2_id;
  logic [4:0]       Rd_ex;
  logic             RUWr_ex;
  logic             DMRd_ex;
  logic             BrTaken_ex;
  logic             DMStall;
  logic             PCWrEn;
  logic             IFIDWrEn;
  logic             IFIDClear;
  logic             IDEXClear;
  logic             IDEXClearNext;
  logic             PipeEn;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output Rs1_id, Rs2_id, UsesRs1_id, UsesRs2_id, Rd_ex, RUWr_ex, DMRd_ex,
           BrTaken_ex, DMStall,
    input  PCWrEn, IFIDWrEn, IFIDClear, IDEXClear, IDEXClearNext, PipeEn,
           StallCount, FlushCount
  );

  modport slave (
    input  Rs1_id, Rs2_id, UsesRs1_id, UsesRs2_id, Rd_ex, RUWr_ex, DMRd_ex,
           BrTaken_ex, DMStall,
    output PCWrEn, IFIDWrEn, IFIDClear, IDEXClear, IDEXClearNext, PipeEn,
           StallCount, FlushCount
  );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                  count <= '0;
    else if (inc && count != '1) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Load-use bubble insertion, taken-branch squash with trailing flush window,
// and whole-pipe freeze on data-memory wait.
module hazard_flush_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic                Clk,
  input  logic                Rst_n,
  hazard_flush_ctrl_if.slave  hz
);

  localparam int             FCW   = $clog2(FLUSH_DEPTH_MAX + 1);
  localparam logic [FCW-1:0] DEPTH = FCW'(FLUSH_DEPTH);

  hz_state_t      state, state_nxt;
  logic [FCW-1:0] fcnt, fcnt_nxt;
  logic           clr_next, clr_next_nxt;
  logic           rs1_hit, rs2_hit, lu;
  logic           stall_inc, flush_inc;

  assign rs1_hit = hz.UsesRs1_id && (hz.Rs1_id == hz.Rd_ex);
  assign rs2_hit = hz.UsesRs2_id && (hz.Rs2_id == hz.Rd_ex);
  assign lu      = hz.DMRd_ex && hz.RUWr_ex && (hz.Rd_ex != REG_X0) && (rs1_hit || rs2_hit);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= RUN;
      fcnt     <= '0;
      clr_next <= 1'b0;
    end else begin
      state    <= state_nxt;
      fcnt     <= fcnt_nxt;
      clr_next <= clr_next_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    fcnt_nxt      = fcnt;
    clr_next_nxt  = clr_next;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    hz.PCWrEn     = 1'b1;
    hz.IFIDWrEn   = 1'b1;
    hz.PipeEn     = 1'b1;
    hz.IFIDClear  = 1'b0;
    hz.IDEXClear  = 1'b0;

    if (!Rst_n) begin
      hz.PCWrEn    = 1'b0;
      hz.IFIDWrEn  = 1'b0;
      hz.PipeEn    = 1'b0;
      hz.IFIDClear = 1'b1;
      hz.IDEXClear = 1'b1;
    end else if (hz.DMStall) begin
      // Freeze everything; the EX instruction is re-evaluated once memory is ready.
      hz.PCWrEn   = 1'b0;
      hz.IFIDWrEn = 1'b0;
      hz.PipeEn   = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (hz.BrTaken_ex) begin
            hz.IFIDClear = 1'b1;
            hz.IDEXClear = 1'b1;
            flush_inc    = 1'b1;
            if (FLUSH_DEPTH > 0) begin
              state_nxt    = FLUSH;
              fcnt_nxt     = DEPTH;
              clr_next_nxt = 1'b1;
            end
          end else if (lu) begin
            // One bubble suffices: the load moves to MEM on the next edge.
            hz.PCWrEn    = 1'b0;
            hz.IFIDWrEn  = 1'b0;
            hz.IDEXClear = 1'b1;
            stall_inc    = 1'b1;
          end
        end
        FLUSH: begin
          hz.IFIDClear = 1'b1;
          if (fcnt <= FCW'(1)) begin
            fcnt_nxt     = '0;
            clr_next_nxt = 1'b0;
            state_nxt    = RUN;
          end else begin
            fcnt_nxt = fcnt - FCW'(1);
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign hz.IDEXClearNext = clr_next;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .inc   (stall_inc),
    .count (hz.StallCount)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .inc   (flush_inc),
    .count (hz.FlushCount)
  );

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench: each step queues its expected outputs, which are popped and
// checked at the following falling edge.
module tb_hazard_flush_ctrl;
  localparam int FLUSH_DEPTH = 2;
  localparam int CNT_W       = 4;

  typedef struct packed {
    logic       pc, ifid, ifclr, exclr, cnext, pipe;
    logic [3:0] sc, fc;
  } exp_t;

  logic Clk, Rst_n;
  int   errs = 0, checks = 0;
  exp_t sb[$];

  hazard_flush_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_flush_ctrl #(.FLUSH_DEPTH(FLUSH_DEPTH), .CNT_W(CNT_W)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .hz    (hz)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic exp_t mk(logic pc, logic ifid, logic ifclr, logic exclr,
                              logic cnext, logic pipe, logic [3:0] sc, logic [3:0] fc);
    exp_t e;
    e.pc = pc; e.ifid = ifid; e.ifclr = ifclr; e.exclr = exclr;
    e.cnext = cnext; e.pipe = pipe; e.sc = sc; e.fc = fc;
    return e;
  endfunction

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic br, logic dms, logic dmrd, logic ruwr, logic [4:0] rd,
                       logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2);
    hz.BrTaken_ex = br;   hz.DMStall    = dms;
    hz.DMRd_ex    = dmrd; hz.RUWr_ex    = ruwr; hz.Rd_ex = rd;
    hz.Rs1_id     = rs1;  hz.UsesRs1_id = u1;
    hz.Rs2_id     = rs2;  hz.UsesRs2_id = u2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
  endtask

  // Load-use on rs2 against x5.
  task automatic lu_rs2(logic br, logic dms);
    drive(br, dms, 1, 1, 5'd5, 5'd1, 1, 5'd5, 1);
  endtask

  task automatic step(string name, exp_t e);
    exp_t got;
    sb.push_back(e);
    @(negedge Clk);
    if (sb.size() == 0) begin
      checks++; errs++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got = sb.pop_front();
      chk({name, ".PCWrEn"},        {3'b0, hz.PCWrEn},        {3'b0, got.pc});
      chk({name, ".IFIDWrEn"},      {3'b0, hz.IFIDWrEn},      {3'b0, got.ifid});
      chk({name, ".IFIDClear"},     {3'b0, hz.IFIDClear},     {3'b0, got.ifclr});
      chk({name, ".IDEXClear"},     {3'b0, hz.IDEXClear},     {3'b0, got.exclr});
      chk({name, ".IDEXClearNext"}, {3'b0, hz.IDEXClearNext}, {3'b0, got.cnext});
      chk({name, ".PipeEn"},        {3'b0, hz.PipeEn},        {3'b0, got.pipe});
      chk({name, ".StallCount"},    hz.StallCount,            got.sc);
      chk({name, ".FlushCount"},    hz.FlushCount,            got.fc);
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst_n = 1'b0;
    idle();
    @(posedge Clk);
    #1;

    // Reset held, then abandoned mid-flush.
    step("rst_hold", mk(0, 0, 1, 1, 0, 0, 0, 0));
    Rst_n = 1'b1; idle();
    step("run_idle", mk(1, 1, 0, 0, 0, 1, 0, 0));
    drive(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step("br0",      mk(1, 1, 1, 1, 0, 1, 0, 0));
    idle();
    step("br0_fl1",  mk(1, 1, 1, 0, 1, 1, 0, 1));
    Rst_n = 1'b0;
    step("rst_midfl", mk(0, 0, 1, 1, 0, 0, 0, 0));
    Rst_n = 1'b1;
    step("rst_rel",  mk(1, 1, 0, 0, 0, 1, 0, 0));

    // Load-use, x0 exemption, rs1 path, unused-operand case.
    lu_rs2(0, 0);
    step("lu_rs2",   mk(0, 0, 0, 1, 0, 1, 0, 0));
    idle();
    step("lu_after", mk(1, 1, 0, 0, 0, 1, 1, 0));
    drive(0, 0, 1, 1, 5'd0, 5'd0, 1, 5'd0, 1);
    step("lu_x0",    mk(1, 1, 0, 0, 0, 1, 1, 0));
    drive(0, 0, 1, 1, 5'd7, 5'd7, 1, 5'd2, 0);
    step("lu_rs1",   mk(0, 0, 0, 1, 0, 1, 1, 0));
    drive(0, 0, 1, 1, 5'd7, 5'd7, 0, 5'd7, 0);
    step("lu_nouse", mk(1, 1, 0, 0, 0, 1, 2, 0));
    drive(0, 0, 0, 1, 5'd7, 5'd7, 1, 5'd2, 0);
    step("lu_noload", mk(1, 1, 0, 0, 0, 1, 2, 0));

    // Branch with two-cycle trailing window; second pulse in FLUSH ignored.
    drive(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step("br1",      mk(1, 1, 1, 1, 0, 1, 2, 0));
    step("br1_fl2",  mk(1, 1, 1, 0, 1, 1, 2, 1));
    idle();
    step("br1_fl1",  mk(1, 1, 1, 0, 1, 1, 2, 1));
    step("br1_done", mk(1, 1, 0, 0, 0, 1, 2, 1));

    // Branch and load-use together: branch wins, LU ignored in FLUSH.
    lu_rs2(1, 0);
    step("both",     mk(1, 1, 1, 1, 0, 1, 2, 1));
    lu_rs2(0, 0);
    step("both_fl2", mk(1, 1, 1, 0, 1, 1, 2, 2));
    step("both_fl1", mk(1, 1, 1, 0, 1, 1, 2, 2));
    idle();
    step("both_done", mk(1, 1, 0, 0, 0, 1, 2, 2));

    // Memory freeze in FLUSH with one flush cycle remaining.
    drive(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step("br2",      mk(1, 1, 1, 1, 0, 1, 2, 2));
    idle();
    step("br2_fl2",  mk(1, 1, 1, 0, 1, 1, 2, 3));
    for (int i = 0; i < 3; i++) begin
      lu_rs2(1, 1);
      step($sformatf("frz_fl%0d", i), mk(0, 0, 0, 0, 1, 0, 2, 3));
    end
    idle();
    step("frz_fl1",  mk(1, 1, 1, 0, 1, 1, 2, 3));
    step("frz_done", mk(1, 1, 0, 0, 0, 1, 2, 3));

    // Freeze in RUN masks both load-use and branch.
    lu_rs2(1, 1);
    step("frz_run",  mk(0, 0, 0, 0, 0, 0, 2, 3));
    idle();
    step("frz_run_after", mk(1, 1, 0, 0, 0, 1, 2, 3));

    // Saturation: 20 load-use cycles from a count of 2.
    for (int i = 0; i < 20; i++) begin
      lu_rs2(0, 0);
      step($sformatf("sat%0d", i),
           mk(0, 0, 0, 1, 0, 1, (2 + i > 15) ? 4'd15 : 4'(2 + i), 3));
    end
    idle();
    step("sat_hold", mk(1, 1, 0, 0, 0, 1, 15, 3));
    lu_rs2(0, 0);
    step("sat_more", mk(0, 0, 0, 1, 0, 1, 15, 3));
    idle();
    step("sat_final", mk(1, 1, 0, 0, 0, 1, 15, 3));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
